// File: rtl/hack_data_mem.sv
// Hack CPU data-memory responder: RAM, screen forwarding and a keyboard FIFO.
// Optional HACK_SCREEN_SHADOW_EN adds an 8192x16 shadow RAM for SCREEN reads.
module hack_data_mem #(
  parameter int RAM_WORDS = 16384,
  parameter int KBD_DEPTH = 4,
  parameter int KBD_AW    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic        fb_we,
  output logic [12:0] fb_addr,
  output logic [15:0] fb_data,
  output logic        kbd_overflow
);

  localparam logic [KBD_AW:0] FULL_CNT = (KBD_AW + 1)'(KBD_DEPTH);

  logic              is_ram, is_screen, is_kbd, is_kstat;
  logic              ram_wr, scr_wr, push, pop, full, empty, ovf_clr;
  logic [15:0]       screen_rd;

  logic [15:0]       ram_q [RAM_WORDS];
  logic [15:0]       kbd_mem_q [KBD_DEPTH];
  logic [KBD_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [KBD_AW:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              fb_we_q;
  logic [12:0]       fb_addr_q;
  logic [15:0]       fb_data_q;

  assign is_ram    = ~addressM[14];
  assign is_screen = (addressM[14:13] == 2'b10);
  assign is_kbd    = (addressM == 15'h6000);
  assign is_kstat  = (addressM == 15'h6001);

  assign ram_wr  = writeM & is_ram;
  assign scr_wr  = writeM & is_screen;
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign kbd_ready = reset_n & ~full;
  assign push    = kbd_valid & kbd_ready;
  // A pop on an empty FIFO is dropped; a simultaneous push still lands.
  assign pop     = writeM & is_kbd & ~empty;
  assign ovf_clr = writeM & is_kstat & outM[15];

  // NOTE: storage arrays have no reset; only pointers/count clear, which
  // discards FIFO contents without a wide reset fan-out.
  always_ff @(posedge clock) begin
    if (ram_wr) ram_q[addressM[13:0]] <= outM;
    if (push)   kbd_mem_q[wr_ptr_q]   <= kbd_data;
  end

`ifdef HACK_SCREEN_SHADOW_EN
  logic [15:0] shadow_q [8192];

  always_ff @(posedge clock) begin
    if (scr_wr) shadow_q[addressM[12:0]] <= outM;
  end

  assign screen_rd = shadow_q[addressM[12:0]];
`else
  assign screen_rd = 16'h0000;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop)  rd_ptr_d = rd_ptr_q + KBD_AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + KBD_AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (KBD_AW + 1)'(1);
      2'b01:   count_d = count_q - (KBD_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (ovf_clr)           ovf_d = 1'b0;
    if (kbd_valid && full) ovf_d = 1'b1;
  end

  always_comb begin
    inM = 16'h0000;
    if (is_ram)         inM = ram_q[addressM[13:0]];
    else if (is_screen) inM = screen_rd;
    else if (is_kbd)    inM = empty ? 16'h0000 : kbd_mem_q[rd_ptr_q];
    else if (is_kstat)  inM = {ovf_q, 11'b0, 4'(count_q)};
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      fb_we_q  <= scr_wr;
      if (scr_wr) begin
        fb_addr_q <= addressM[12:0];
        fb_data_q <= outM;
      end
    end
  end

  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_data      = fb_data_q;
  assign kbd_overflow = ovf_q;

endmodule

// File: tb/tb_hack_data_mem.sv
// Self-checking bench for hack_data_mem: directed scenarios plus randomized
// traffic compared every cycle against a queue/array model of the memory map.
module tb_hack_data_mem;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] inM;
  logic [15:0] kd;
  logic        kv;
  logic        kready, fb_we, ovf;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  hack_data_mem #(.RAM_WORDS(16384), .KBD_DEPTH(DEPTH), .KBD_AW(2)) dut (
    .clock(clock), .reset_n(reset_n), .addressM(addr), .outM(wdata),
    .writeM(we), .inM(inM), .kbd_data(kd), .kbd_valid(kv),
    .kbd_ready(kready), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .kbd_overflow(ovf)
  );

  always #5 clock = ~clock;

  // Reference model: plain arrays and a queue.
  logic [15:0] ram_m [16384];
  bit          ram_wr [16384];
  logic [15:0] shd_m [8192];
  bit          shd_wr [8192];
  logic [15:0] q [$];
  bit          ovf_m;
  bit          fbwe_m;
  logic [12:0] fba_m;
  logic [15:0] fbd_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    ovf_m  = 1'b0;
    fbwe_m = 1'b0;
    fba_m  = '0;
    fbd_m  = '0;
  endfunction

  function automatic void model_edge();
    int a;
    bit full, do_pop, do_push;
    if (!reset_n) return;
    a       = int'(addr);
    full    = (q.size() == DEPTH);
    do_pop  = we && a == 'h6000 && q.size() > 0;
    do_push = kv && !full;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(kd);
    if (kv && full) ovf_m = 1'b1;
    else if (we && a == 'h6001 && wdata[15]) ovf_m = 1'b0;
    if (we && a < 'h4000) begin
      ram_m[a]  = wdata;
      ram_wr[a] = 1'b1;
    end
    fbwe_m = we && a >= 'h4000 && a < 'h6000;
    if (fbwe_m) begin
      fba_m = 13'(a - 'h4000);
      fbd_m = wdata;
      shd_m[a - 'h4000]  = wdata;
      shd_wr[a - 'h4000] = 1'b1;
    end
  endfunction

  // Returns 1 when the expected read value is defined (written or fixed).
  function automatic bit exp_inm(output logic [15:0] v);
    int a;
    a = int'(addr);
    v = 16'h0000;
    if (a < 'h4000) begin
      v = ram_m[a];
      return ram_wr[a];
    end else if (a < 'h6000) begin
`ifdef HACK_SCREEN_SHADOW_EN
      v = shd_m[a - 'h4000];
      return shd_wr[a - 'h4000];
`else
      return 1'b1;
`endif
    end else if (a == 'h6000) begin
      v = (q.size() > 0) ? q[0] : 16'h0000;
    end else if (a == 'h6001) begin
      v = {ovf_m, 11'b0, 4'(q.size())};
    end
    return 1'b1;
  endfunction

  always @(negedge clock) begin
    logic [15:0] v;
    if (chk_en) begin
      check("kbd_ready", kready, reset_n && q.size() < DEPTH);
      check("fb_we", fb_we, fbwe_m);
      check("fb_addr", fb_addr, fba_m);
      check("fb_data", fb_data, fbd_m);
      check("kbd_overflow", ovf, ovf_m);
      if (exp_inm(v)) check("inM", inM, v);
    end
  end

  task automatic drive(input logic [14:0] a, input logic [15:0] d, input logic w,
                       input logic v, input logic [15:0] k);
    addr = a; wdata = d; we = w; kv = v; kd = k;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    logic [14:0] ra;
    int r;
    drive(15'h6001, 16'h0, 1'b0, 1'b0, 16'h0);
    model_reset();
    #12;
    check("rst_kbd_ready", kready, 1'b0);
    check("rst_fb_we", fb_we, 1'b0);
    check("rst_fb_addr", fb_addr, 13'h0);
    check("rst_overflow", ovf, 1'b0);
    check("rst_kstat", inM, 16'h0000);
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // RAM write/readback at both ends of the window
    drive(15'h0010, 16'h1234, 1'b1, 1'b0, 16'h0); step();
    drive(15'h3FFF, 16'hBEEF, 1'b1, 1'b0, 16'h0); step();
    drive(15'h0010, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t1_ram_0010", inM, 16'h1234);
    drive(15'h3FFF, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t1_ram_3fff", inM, 16'hBEEF);
    step();

    // Screen write produces a single framebuffer pulse
    drive(15'h4005, 16'h00FF, 1'b1, 1'b0, 16'h0); step();
    drive(15'h4005, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t2_fb_we", fb_we, 1'b1);
    check("t2_fb_addr", fb_addr, 13'h0005);
    check("t2_fb_data", fb_data, 16'h00FF);
`ifdef HACK_SCREEN_SHADOW_EN
    check("t2_screen_rd", inM, 16'h00FF);
`else
    check("t2_screen_rd", inM, 16'h0000);
`endif
    step();
    check("t2_fb_we_drop", fb_we, 1'b0);

    // FIFO order, pop, pop on empty
    drive(15'h0, 16'h0, 1'b0, 1'b1, 16'h0041); step();
    drive(15'h0, 16'h0, 1'b0, 1'b1, 16'h0042); step();
    drive(15'h6000, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t3_head0", inM, 16'h0041);
    drive(15'h6000, 16'h0, 1'b1, 1'b0, 16'h0); step();
    drive(15'h6000, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t3_head1", inM, 16'h0042);
    drive(15'h6000, 16'h0, 1'b1, 1'b0, 16'h0); step(); step();
    drive(15'h6000, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t3_empty_head", inM, 16'h0000);
    drive(15'h6001, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t3_empty_kstat", inM, 16'h0000);
    step();

    // Fill, overflow, clear
    for (int i = 0; i < 4; i++) begin
      drive(15'h0, 16'h0, 1'b0, 1'b1, 16'(16'h61 + i)); step();
    end
    drive(15'h6001, 16'h0, 1'b0, 1'b1, 16'h0099); #1;
    check("t4_ready_full", kready, 1'b0);
    check("t4_kstat_full", inM, 16'h0004);
    step();
    drive(15'h6001, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t4_kstat_ovf", inM, 16'h8004);
    drive(15'h6001, 16'h8000, 1'b1, 1'b0, 16'h0); step();
    drive(15'h6001, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t4_kstat_clr", inM, 16'h0004);
    drive(15'h6000, 16'h0, 1'b1, 1'b0, 16'h0); step(); step();

    // Simultaneous push/pop with count=2
    drive(15'h6000, 16'h0, 1'b1, 1'b1, 16'h0043); step();
    drive(15'h6001, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t5_kstat", inM, 16'h0002);
    drive(15'h6000, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t5_head0", inM, 16'h0064);
    drive(15'h6000, 16'h0, 1'b1, 1'b0, 16'h0); step();
    drive(15'h6000, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t5_head1", inM, 16'h0043);
    drive(15'h6000, 16'h0, 1'b1, 1'b0, 16'h0); step();
    drive(15'h6000, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t5_head_empty", inM, 16'h0000);
    step();

    // Async reset during a screen write with count=3
    for (int i = 0; i < 3; i++) begin
      drive(15'h0, 16'h0, 1'b0, 1'b1, 16'(16'h71 + i)); step();
    end
    drive(15'h0020, 16'hCAFE, 1'b1, 1'b0, 16'h0); step();
    drive(15'h4100, 16'h5555, 1'b1, 1'b0, 16'h0); step();
    check("t6_fb_we_pre", fb_we, 1'b1);
    reset_n = 1'b0;
    model_reset();
    drive(15'h6001, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t6_fb_we_rst", fb_we, 1'b0);
    check("t6_ready_rst", kready, 1'b0);
    check("t6_kstat_rst", inM, 16'h0000);
    drive(15'h6000, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t6_kbd_rst", inM, 16'h0000);
    drive(15'h0020, 16'h0, 1'b0, 1'b0, 16'h0); #1;
    check("t6_ram_keep", inM, 16'hCAFE);
    step();
    reset_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      ra = 15'($urandom_range(0, 63));
      else if (r < 30) ra = 15'('h3FC0 + $urandom_range(0, 63));
      else if (r < 45) ra = 15'('h4000 + $urandom_range(0, 31));
      else if (r < 48) ra = 15'('h4000 + $urandom_range(0, 8191));
      else if (r < 75) ra = 15'h6000;
      else if (r < 90) ra = 15'h6001;
      else             ra = 15'('h6002 + $urandom_range(0, 'h1FFD));
      if ($urandom_range(0, 499) == 0) begin
        drive(ra, 16'h0, 1'b0, 1'b0, 16'h0);
        reset_n = 1'b0;
        model_reset();
        step();
        reset_n = 1'b1;
      end else begin
        drive(ra, 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < 15), 16'($urandom));
        step();
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
